shifter_pipe: RTL

Parametrised, pipelined barrel shifter that generalises the team's 16-bit combinational shifter to any power-of-two width and adds arithmetic right shift. It splits the log2(WIDTH) shift levels across STAGES register stages, with valid/ready handshakes on both sides. It sits between the decode/operand stage and the execute result mux. It accepts one operation per cycle and applies back-pressure from the downstream consumer.

---
 rtl/shifter_pipe_if.sv | 37 +++
 rtl/shifter_pipe.sv | 107 ++++++++++
 2 files changed

// File: rtl/shifter_pipe_if.sv
// rtl/shifter_pipe_if.sv - operand/result handshake bundle for shifter_pipe
//
// Groups the upstream (in_*) and downstream (out_*) valid/ready channels.
//   master : the side that supplies operands and consumes results
//   slave  : the shifter itself
// Signals:
//   in_valid/in_ready   operand handshake
//   in_data [WIDTH]     operand
//   in_cnt  [CW]        shift/rotate amount
//   in_op   [3]         operation select
//   out_valid/out_ready result handshake
//   out_data [WIDTH]    result
//   out_zero            out_data == 0, meaningful while out_valid=1
interface shifter_pipe_if #(
    parameter int WIDTH = 16,
    parameter int CW    = $clog2(WIDTH)
);
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] in_data;
    logic [CW-1:0]    in_cnt;
    logic [2:0]       in_op;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] out_data;
    logic             out_zero;

    modport master (
        output in_valid, in_data, in_cnt, in_op, out_ready,
        input  in_ready, out_valid, out_data, out_zero
    );

    modport slave (
        input  in_valid, in_data, in_cnt, in_op, out_ready,
        output in_ready, out_valid, out_data, out_zero
    );
endinterface

// File: rtl/shifter_pipe.sv
// rtl/shifter_pipe.sv - pipelined barrel shifter/rotator with valid/ready handshakes
//
// Ports:
//   clk  rising-edge clock
//   rst  asynchronous active-high reset
//   bus  shifter_pipe_if.slave (in_* operand channel, out_* result channel)
// Parameters:
//   WIDTH   data width, power of two, 4..64
//   STAGES  register stages, 1..log2(WIDTH)
//
// Ops: 000 rotl, 001 shl, 010 rotr, 011 lsr, 100 asr, 101..111 pass-through.
// Shift level k (amount 2^k) runs in stage (k*STAGES)/CW, LSB level first.
// The whole pipeline advances as one when the output slot is empty or being
// drained; bubbles travel through as valid=0 slots.
module shifter_pipe #(
    parameter int WIDTH  = 16,
    parameter int STAGES = 2
) (
    input  logic            clk,
    input  logic            rst,
    shifter_pipe_if.slave   bus
);
    localparam int CW = $clog2(WIDTH);

    logic [WIDTH-1:0]  data_q [STAGES];
    logic [CW-1:0]     cnt_q  [STAGES];
    logic [2:0]        op_q   [STAGES];
    logic [STAGES-1:0] vld_q;

    logic [WIDTH-1:0]  data_d [STAGES];
    logic              adv;

    // One shift level: move d by 2^k positions according to op.
    function automatic logic [WIDTH-1:0] level(
        input logic [WIDTH-1:0] d,
        input logic [2:0]       op,
        input int               k
    );
        int               sh;
        logic [WIDTH-1:0] r;
        sh = 1 << k;
        case (op)
            3'b000:  r = (d << sh) | (d >> (WIDTH - sh));
            3'b001:  r = d << sh;
            3'b010:  r = (d >> sh) | (d << (WIDTH - sh));
            3'b011:  r = d >> sh;
            3'b100:  r = $signed(d) >>> sh;
            default: r = d;
        endcase
        return r;
    endfunction

    assign adv          = bus.out_ready | ~vld_q[STAGES-1];
    assign bus.in_ready = adv;

    // Each stage takes the previous stage register (stage 0 takes the input
    // port) and applies only the levels assigned to it.
    always_comb begin
        logic [WIDTH-1:0] cd;
        logic [CW-1:0]    cc;
        logic [2:0]       co;
        int               src;
        cd = bus.in_data;
        cc = bus.in_cnt;
        co = bus.in_op;
        for (int s = 0; s < STAGES; s++) begin
            src = (s > 0) ? s - 1 : 0;
            if (s > 0) begin
                cd = data_q[src];
                cc = cnt_q[src];
                co = op_q[src];
            end
            for (int k = 0; k < CW; k++) begin
                if (((k * STAGES) / CW) == s && cc[k]) begin
                    cd = level(cd, co, k);
                end
            end
            data_d[s] = cd;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            vld_q <= '0;
            for (int s = 0; s < STAGES; s++) begin
                data_q[s] <= '0;
                cnt_q[s]  <= '0;
                op_q[s]   <= '0;
            end
        end else if (adv) begin
            vld_q[0]  <= bus.in_valid;
            data_q[0] <= data_d[0];
            cnt_q[0]  <= bus.in_cnt;
            op_q[0]   <= bus.in_op;
            for (int s = 1; s < STAGES; s++) begin
                vld_q[s]  <= vld_q[s-1];
                data_q[s] <= data_d[s];
                cnt_q[s]  <= cnt_q[s-1];
                op_q[s]   <= op_q[s-1];
            end
        end
    end

    assign bus.out_valid = vld_q[STAGES-1];
    assign bus.out_data  = data_q[STAGES-1];
    assign bus.out_zero  = vld_q[STAGES-1] & ~|data_q[STAGES-1];
endmodule
